// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register word addresses and address width.
package gpio_pkg;

  localparam int GPIO_ADDR_W = 4;

  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_OUT  = 4'h0;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_DIR  = 4'h1;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_IN   = 4'h2;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_SET  = 4'h3;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_CLR  = 4'h4;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_TGL  = 4'h5;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_EN   = 4'h6;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_POL  = 4'h7;
  localparam logic [GPIO_ADDR_W-1:0] GPIO_ADDR_STAT = 4'h8;

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit, multi-stage flop synchroniser for asynchronous pad inputs.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: OUT/DIR registers with atomic set/clear/toggle, synchronised IN,
// and edge interrupts built only when GPIO_IRQ_EN is defined.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GPIO_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   we,
  output logic [WIDTH-1:0]       rdata_out,
  input  logic [WIDTH-1:0]       gpio_in,
  output logic [WIDTH-1:0]       gpio_out,
  output logic [WIDTH-1:0]       gpio_oe,
  output logic                   irq
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] in_sync;

  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gpio_in),
    .q_o   (in_sync)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (we) begin
      case (addr)
        GPIO_ADDR_OUT: out_d = wdata;
        GPIO_ADDR_DIR: dir_d = wdata;
        GPIO_ADDR_SET: out_d = out_q | wdata;
        GPIO_ADDR_CLR: out_d = out_q & ~wdata;
        GPIO_ADDR_TGL: out_d = out_q ^ wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] edge_hit;
  logic             irq_q;

  always_comb begin
    en_d  = en_q;
    pol_d = pol_q;
    w1c   = '0;
    if (we) begin
      case (addr)
        GPIO_ADDR_EN:   en_d  = wdata;
        GPIO_ADDR_POL:  pol_d = wdata;
        GPIO_ADDR_STAT: w1c   = wdata;
        default: ;
      endcase
    end
    // A pin changed and its new level matches the polarity: 1 = rising, 0 = falling.
    edge_hit = (in_sync ^ prev_q) & ~(in_sync ^ pol_q);
    // Set is OR-ed in after the clear, so a same-cycle edge beats W1C.
    stat_d   = (stat_q & ~w1c) | (edge_hit & en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      prev_q <= in_sync;
      irq_q  <= |(stat_q & en_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_out = '0;
    case (addr)
      GPIO_ADDR_OUT:  rdata_out = out_q;
      GPIO_ADDR_DIR:  rdata_out = dir_q;
      GPIO_ADDR_IN:   rdata_out = in_sync;
`ifdef GPIO_IRQ_EN
      GPIO_ADDR_EN:   rdata_out = en_q;
      GPIO_ADDR_POL:  rdata_out = pol_q;
      GPIO_ADDR_STAT: rdata_out = stat_q;
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised general-purpose I/O bank: the next-generation replacement for the single 8-bit output register on the peripheral register bus. It adds per-pin direction control, atomic set/clear/toggle writes, a synchronised input path and optional edge-triggered interrupts. It sits behind the peripheral address decoder and drives the chip's GPIO pads and one interrupt line.

## Interface
- WIDTH, 8, number of GPIO pins (1..32)
- SYNC_STAGES, 2, input synchroniser depth (>=2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  4  register word address
- wdata  in  WIDTH  write data
- we  in  1  write strobe, one-cycle, sampled on rising clk
- rdata_out  out  WIDTH  read data, combinational from addr
- gpio_in  in  WIDTH  pad inputs, asynchronous to clk
- gpio_out  out  WIDTH  pad output values
- gpio_oe  out  WIDTH  pad output enables (1 = drive)
- irq  out  1  level interrupt, registered

## Operation
- Register map (addr): 0x0 OUT rw; 0x1 DIR rw; 0x2 IN ro (synchronised gpio_in); 0x3 SET wo (OUT |= wdata); 0x4 CLR wo (OUT &= ~wdata); 0x5 TGL wo (OUT ^= wdata); 0x6 IRQ_EN rw; 0x7 IRQ_POL rw (1 = rising, 0 = falling); 0x8 IRQ_STAT rw1c.
- gpio_out = OUT; gpio_oe = DIR. Read of a wo or unmapped address returns 0; write to ro or unmapped address is ignored.
- Input path: each bit passes through SYNC_STAGES flops, then one "previous" flop. Edge = sync != prev, qualified by IRQ_POL per bit.
- Edge detection runs on all pins regardless of DIR, so output loopback can be observed.
- IRQ_STAT[i] sets on a qualified edge when IRQ_EN[i] = 1; clears only by writing 1 to that bit at 0x8.
- Same-cycle set and W1C on one bit: set wins (bit stays 1).
- irq register loads |(IRQ_STAT & IRQ_EN) every cycle. Clearing IRQ_EN masks irq without clearing status.
- Reset: OUT, DIR, IRQ_EN, IRQ_POL, IRQ_STAT, synchroniser and prev flops = 0. gpio_out = 0, gpio_oe = 0, irq = 0. Reset takes effect mid-operation, immediately and asynchronously. Leaving reset with an input high yields a rising edge SYNC_STAGES+1 cycles later; this is intended behaviour.

## Timing
- Register writes take effect at the clk edge where we = 1; rdata_out and pad outputs reflect the new value in the following cycle.
- gpio_in change -> visible at IN after SYNC_STAGES edges.
- Edge -> IRQ_STAT set 1 edge after IN updates (SYNC_STAGES+1 total).
- irq asserts 1 edge after IRQ_STAT (SYNC_STAGES+2 total).
- W1C -> irq deasserts 1 edge after IRQ_STAT clears.
- Pulses narrower than one clk period may be missed; this is not guaranteed.

## Configuration
- GPIO_IRQ_EN defined: interrupt logic (IRQ_EN, IRQ_POL, IRQ_STAT, prev flops, irq register) is built.
- GPIO_IRQ_EN undefined: addresses 0x6–0x8 behave as unmapped and irq is tied to 0. The synchroniser and IN are still present.

## Structure
- Package gpio_pkg: address constants (GPIO_ADDR_OUT … GPIO_ADDR_STAT), address width constant.
- Sub-module gpio_sync: WIDTH-bit, SYNC_STAGES-deep synchroniser with async active-low reset. It is reusable for other pad inputs.
- All remaining logic lives in gpio_bank.

## Test plan
- Reset, then read all addresses -> all 0; gpio_oe = 0, irq = 0.
- Write OUT = 0xA5, SET 0x0F, CLR 0x81, TGL 0xFF -> gpio_out goes A5, AF, 2E, D1 on successive cycles.
- DIR = 0xFF, gpio_in 0x00→0x3C -> IN reads 0x3C exactly SYNC_STAGES cycles after the change, not earlier.
- IRQ_EN = 0x01, IRQ_POL = 0x01, gpio_in[0] 0→1 -> IRQ_STAT = 0x01 at +3 cycles and irq = 1 at +4; falling edge on bit 0 does not set it.
- With IRQ_STAT[0] = 1, issue W1C 0x01 in the same cycle as a new rising edge on bit 0 -> IRQ_STAT[0] stays 1 and irq stays 1. A later W1C with no edge -> irq = 0 one cycle after.
- Build without GPIO_IRQ_EN, write 0xFF to 0x6 and toggle inputs -> reads of 0x6–0x8 return 0 and irq stays 0.
